// File: rtl/alu_seq.sv
// Registered picoMIPS ALU: single-cycle move/add/sub/adc plus an N-cycle
// shift-add multiplier that gives the low or high half of the 2N-bit product.
module alu_seq #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2:0]     func,
    input  logic [1:0]     a_sel,
    input  logic [1:0]     b_sel,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic [N:0]     switches,
    input  logic [N-1:0]   immediate,
    input  logic           imm,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result,
    output logic [3:0]     flags
);

    localparam logic [2:0] FuncRa   = 3'b000;
    localparam logic [2:0] FuncRb   = 3'b001;
    localparam logic [2:0] FuncRadd = 3'b010;
    localparam logic [2:0] FuncRsub = 3'b011;
    localparam logic [2:0] FuncMull = 3'b100;
    localparam logic [2:0] FuncMulh = 3'b101;
    localparam logic [2:0] FuncRadc = 3'b110;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e          state_q;
    logic [N-1:0]    result_q;
    logic [3:0]      flags_q;
    logic            done_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [2:0]      func_q;
    logic [2*N-1:0]  prod_q;
    logic [CW-1:0]   count_q;

    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [N:0]      sum;
    logic [N-1:0]    sc_res;
    logic            sc_c;
    logic            sc_v;
    logic [2*N-1:0]  partial;
    logic [2*N-1:0]  prod_next;
    logic [N-1:0]    mul_res;
    logic            mul_cv;
    logic            is_mul;

    always_comb begin
        unique case (a_sel)
            2'b01:   op_a = switches[N-1:0];
            2'b10:   op_a = {N{switches[N]}};
            default: op_a = a_in;
        endcase
        unique case (b_sel)
            2'b01:   op_b = switches[N-1:0];
            2'b10:   op_b = {N{switches[N]}};
            default: op_b = b_in;
        endcase
        if (imm) begin
            op_b = immediate;
        end
    end

    always_comb begin
        sum    = '0;
        sc_res = op_a;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        unique case (func)
            FuncRb: begin
                sc_res = op_b;
            end
            FuncRadd, FuncRadc: begin
                // Carry-in comes from the C flag registered before this edge.
                sum    = {1'b0, op_a} + {1'b0, op_b}
                       + {{N{1'b0}}, (func == FuncRadc) ? flags_q[0] : 1'b0};
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (op_a[N-1] == op_b[N-1]) && (sum[N-1] != op_a[N-1]);
            end
            FuncRsub: begin
                // Top bit of the N+1-bit difference is the borrow (A < B).
                sum    = {1'b0, op_a} - {1'b0, op_b};
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (op_a[N-1] != op_b[N-1]) && (sum[N-1] != op_a[N-1]);
            end
            default: begin
                sc_res = op_a;
            end
        endcase
    end

    always_comb begin
        partial   = b_q[count_q] ? ({{N{1'b0}}, a_q} << count_q) : '0;
        prod_next = prod_q + partial;
        if (func_q == FuncMulh) begin
            mul_res = prod_next[2*N-1:N];
            mul_cv  = 1'b0;
        end else begin
            mul_res = prod_next[N-1:0];
            mul_cv  = |prod_next[2*N-1:N];
        end
    end

    assign is_mul = (func == FuncMull) || (func == FuncMulh);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= FuncRa;
            prod_q   <= '0;
            count_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        func_q <= func;
                        if (is_mul) begin
                            prod_q  <= '0;
                            count_q <= '0;
                            state_q <= StMul;
                        end else begin
                            result_q <= sc_res;
                            flags_q  <= {sc_v, sc_res[N-1], sc_res == '0, sc_c};
                            done_q   <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    prod_q <= prod_next;
                    if (count_q == CW'(N - 1)) begin
                        result_q <= mul_res;
                        flags_q  <= {mul_cv, mul_res[N-1], mul_res == '0, mul_cv};
                        done_q   <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = (state_q == StMul);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8) with hand-computed results and {V,N,Z,C} flags.
module tb_alu_seq;
    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   func;
    logic [1:0]   a_sel;
    logic [1:0]   b_sel;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N:0]   switches;
    logic [N-1:0] immediate;
    logic         imm;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [3:0]   flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .func      (func),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .a_in      (a_in),
        .b_in      (b_in),
        .switches  (switches),
        .immediate (immediate),
        .imm       (imm),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start strobe; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [1:0] as, input logic [1:0] bs,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic im, input logic [7:0] iv);
        @(negedge clk);
        func = f; a_sel = as; b_sel = bs; a_in = a; b_in = b; imm = im; immediate = iv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        imm   = 1'b0;
    endtask

    task automatic check_single(input string tag, input logic [7:0] er, input logic [3:0] ef);
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".result"}, 32'(result), 32'(er));
        check_eq({tag, ".flags"}, 32'(flags), 32'(ef));
        @(posedge clk);
        #1;
        check_eq({tag, ".done_low"}, 32'(done), 32'd0);
    endtask

    task automatic wait_mul(input string tag, input logic [7:0] er, input logic [3:0] ef);
        int cycles;
        cycles = 0;
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq({tag, ".latency"}, 32'(cycles), 32'(N));
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".result"}, 32'(result), 32'(er));
        check_eq({tag, ".flags"}, 32'(flags), 32'(ef));
        check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, ".done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; func = 3'd0; a_sel = 2'd0; b_sel = 2'd0;
        a_in = '0; b_in = '0; switches = '0; immediate = '0; imm = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst.result", 32'(result), 32'd0);
        check_eq("rst.flags", 32'(flags), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);

        // RADC as first op: carry-in must be 0 -> 3+4 = 7
        issue(3'b110, 2'b00, 2'b00, 8'h03, 8'h04, 1'b0, 8'h00);
        check_single("adc_first", 8'h07, 4'b0000);

        issue(3'b010, 2'b00, 2'b00, 8'h7F, 8'h01, 1'b0, 8'h00);
        check_single("add_ovf", 8'h80, 4'b1100);

        issue(3'b011, 2'b00, 2'b00, 8'h05, 8'h07, 1'b0, 8'h00);
        check_single("sub_borrow", 8'hFE, 4'b0101);
        issue(3'b011, 2'b00, 2'b00, 8'h07, 8'h05, 1'b0, 8'h00);
        check_single("sub_pos", 8'h02, 4'b0000);

        issue(3'b100, 2'b00, 2'b00, 8'h10, 8'h20, 1'b0, 8'h00);
        wait_mul("mull_10x20", 8'h00, 4'b1011);
        issue(3'b101, 2'b00, 2'b00, 8'h10, 8'h20, 1'b0, 8'h00);
        wait_mul("mulh_10x20", 8'h02, 4'b0000);

        issue(3'b010, 2'b00, 2'b00, 8'hFF, 8'h01, 1'b0, 8'h00);
        check_single("add_carry", 8'h00, 4'b0011);
        issue(3'b110, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
        check_single("adc_cin", 8'h01, 4'b0000);

        // Back-to-back: second start lands in the cycle done=1
        issue(3'b000, 2'b00, 2'b00, 8'h55, 8'h11, 1'b0, 8'h00);
        check_eq("b2b.first_done", 32'(done), 32'd1);
        check_eq("b2b.first_result", 32'(result), 32'h55);
        issue(3'b001, 2'b00, 2'b00, 8'h22, 8'h66, 1'b0, 8'h00);
        check_single("b2b_rb", 8'h66, 4'b0000);

        issue(3'b111, 2'b00, 2'b00, 8'h80, 8'h01, 1'b0, 8'h00);
        check_single("reserved_ra", 8'h80, 4'b0100);

        // Multiply aborted by reset; starts during busy must be ignored
        issue(3'b100, 2'b00, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            func = 3'b010; a_in = 8'h01; b_in = 8'h01; start = 1'b1;
            reset = (c >= 4);
            @(posedge clk);
            #1;
            if (c < 4) begin
                check_eq("abort.busy", 32'(busy), 32'd1);
                check_eq("abort.no_done", 32'(done), 32'd0);
                check_eq("abort.held", 32'(result), 32'h80);
            end
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check_eq("abort.result", 32'(result), 32'd0);
        check_eq("abort.flags", 32'(flags), 32'd0);
        check_eq("abort.busy_low", 32'(busy), 32'd0);
        seen = 0;
        repeat (N + 3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_eq("abort.done_count", 32'(seen), 32'd0);

        issue(3'b100, 2'b00, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00);
        wait_mul("mull_ffxff", 8'h01, 4'b1001);
        issue(3'b101, 2'b00, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00);
        wait_mul("mulh_ffxff", 8'hFE, 4'b0100);

        // Operand muxing: SW_LO=0xA5, SW_HI=0xFF
        switches = 9'h1A5;
        issue(3'b010, 2'b01, 2'b10, 8'h00, 8'h00, 1'b0, 8'h00);
        check_single("mux_add", 8'hA4, 4'b0101);
        issue(3'b001, 2'b00, 2'b00, 8'h00, 8'h77, 1'b1, 8'h03);
        check_single("imm_rb", 8'h03, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the picoMIPS combinational ALU. Executes one operation per start strobe: single-cycle for move/add/subtract and N-cycle shift-add for multiply. It also produces a full 2N-bit product, selectable as low or high half, and an add-with-carry that uses the stored C flag. It sits between the register file / switch inputs and the writeback mux, and holds result and flags until the next operation completes.

## Interface
Parameters:
- N, 8, datapath width in bits; N >= 4.
- CW, $clog2(N+1), multiply iteration counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only when busy=0.
- func  in  3  operation code: 000 RA, 001 RB, 010 RADD, 011 RSUB, 100 RMULL, 101 RMULH, 110 RADC, 111 reserved (executes as RA).
- a_sel, b_sel  in  2  operand source: 00 REG, 01 SW_LO (switches[N-1:0]), 10 SW_HI ({N{switches[N]}}), 11 REG.
- a_in, b_in  in  N  register operands.
- switches  in  N+1  external switch inputs.
- immediate  in  N  instruction immediate.
- imm  in  1  1 = immediate overrides B after b_sel mux.
- busy  out  1  multiply in progress; start ignored.
- done  out  1  one-cycle pulse: result and flags updated this cycle.
- result  out  N  registered result; held between operations.
- flags  out  4  registered {V,N,Z,C}; held between operations.

## Operation
- Operand muxes are combinational and are captured into operand registers when start is accepted (start=1 and busy=0).
- The FSM has two states, IDLE and MUL. Reset sets IDLE, result=0, flags=0, done=0, busy=0, product=0, count=0.
- IDLE + start, func not in {RMULL, RMULH}: result and flags are computed and registered on the same edge. done=1 next cycle. FSM stays in IDLE.
- IDLE + start, func in {RMULL, RMULH}: capture A, B, and func. Clear the 2N-bit product. count=0. Go to MUL.
- MUL: each cycle, if B[count]=1, add A<<count to the product (unsigned). Increment count. When count reaches N-1, register the result and flags, pulse done, and return to IDLE.
- Arithmetic is N-bit modulo 2^N. The product is 2N-bit unsigned and exact.
- RA/RB/reserved: result = A or B. V=0, C=0.
- RADD: result = A+B. C = carry-out. V = signed overflow.
- RSUB: result = A-B. C = borrow (1 iff A<B unsigned; picoMIPS inverted carry). V = signed overflow.
- RADC: result = A+B+C_stored. C and V are computed as for RADD including carry-in.
- RMULL: result = product[N-1:0]. V = C = (product[2N-1:N] != 0).
- RMULH: result = product[2N-1:N]. V=0, C=0.
- Z and N are always derived from the registered result: Z = result==0, N = result[N-1].
- start while busy=1 is ignored: no queueing, no error.
- Reset during MUL aborts immediately. result and flags return to 0 and no done pulse is produced.
- RADC immediately after reset uses C=0.

## Timing
- Single-cycle ops: start accepted at edge k. result, flags, and done are valid after edge k. Latency is 1.
- Multiply: start accepted at edge k. busy=1 after edges k through k+N-1. result, flags, and done=1 follow edge k+N. Latency is N+1.
- done is high for exactly one cycle per accepted operation.
- A new start is accepted in the same cycle done=1 (back-to-back).
- The C used by RADC is the flags[0] value registered before the accepting edge.
- No combinational path exists from any input to result, flags, or done. busy depends only on state.

## Test plan
- Reset, then RADD with a_in=0x7F, b_in=0x01 (N=8) -> one cycle later result=0x80, flags V=1 N=1 Z=0 C=0, done pulses once.
- RSUB with a_in=0x05, b_in=0x07 -> result=0xFE, C=1 (borrow), N=1, V=0. Then RSUB 0x07-0x05 -> result=0x02, C=0.
- RMULL with A=0x10, B=0x20 -> busy high for 8 cycles, done 9 cycles after start, result=0x00, Z=1, V=C=1. Then RMULH with the same operands -> result=0x02, V=C=0.
- RADD 0xFF+0x01 (expect result=0x00, Z=1, C=1), then RADC 0x00+0x00 -> result=0x01, C=0. Also: RADC as the first op after reset -> C_in=0.
- Start RMULL 0xFF*0xFF, assert start with RADD on cycles 2-5 (ignored), then assert reset on cycle 4 -> result=0, flags=0, busy=0, and no done. Re-run without reset -> RMULL=0x01, RMULH=0xFE.
- Operand muxing: switches=0x1A5, a_sel=SW_LO, b_sel=SW_HI, RADD -> 0xA5+0xFF=0xA4, C=1. Then imm=1, immediate=0x03, RB -> result=0x03.
